// File: rtl/alu_mdu_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mdu_if
//  Description : Bus bundle between the execute stage and the ALU/MDU block.
//                Carries operands, op selects, the MD issue strobe and the
//                ALU result, MDU busy flag and HI/LO registers.
//                master  : execute-stage control side (drives operands/ops)
//                slave   : alu_mdu (drives C, busy, HI, LO, ovf)
//                Optional: ALU_OVF_EN adds the ovf signal.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUOp;
    logic [WIDTH-1:0] C;
    logic [2:0]       MDOp;
    logic             start;
    logic             busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
`ifdef ALU_OVF_EN
    logic             ovf;

    modport master (
        output A, B, ALUOp, MDOp, start,
        input  C, busy, HI, LO, ovf
    );

    modport slave (
        input  A, B, ALUOp, MDOp, start,
        output C, busy, HI, LO, ovf
    );
`else
    modport master (
        output A, B, ALUOp, MDOp, start,
        input  C, busy, HI, LO
    );

    modport slave (
        input  A, B, ALUOp, MDOp, start,
        output C, busy, HI, LO
    );
`endif
endinterface
`default_nettype wire

// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mdu
//  Description : Execute-stage arithmetic unit.
//                - Combinational ALU: add/sub/logic/compare/shift/lui -> C.
//                - Multi-cycle multiply/divide unit with architectural HI/LO
//                  registers and a registered busy flag.
//  Ports       : clk    rising-edge clock
//                reset  asynchronous, active-high reset
//                bus    alu_mdu_if.slave:
//                         A, B    operands (A[SH-1:0] is the shift amount)
//                         ALUOp   ALU operation, C = ALU result
//                         MDOp    0/7 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                                 5 MTHI, 6 MTLO; issued when start=1
//                         busy    MDU computing
//                         HI, LO  MDU result registers
//                         ovf     signed add/sub overflow (ALU_OVF_EN only)
//  Config      : `define ALU_OVF_EN to add the ovf output and its logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    alu_mdu_if.slave bus
);

    localparam int c_sh      = $clog2(WIDTH);
    localparam int c_max_cyc = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    // +1 keeps the counter at least one bit wide when both latencies are 1
    localparam int c_cnt_w   = $clog2(c_max_cyc + 1);

    localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(MULT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(DIV_CYCLES - 1);
    localparam logic [WIDTH-1:0]   c_min       = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] c_md_mult  = 3'd1;
    localparam logic [2:0] c_md_multu = 3'd2;
    localparam logic [2:0] c_md_div   = 3'd3;
    localparam logic [2:0] c_md_divu  = 3'd4;
    localparam logic [2:0] c_md_mthi  = 3'd5;
    localparam logic [2:0] c_md_mtlo  = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------------
    logic [c_sh-1:0]  w_shamt;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu;

    assign w_shamt = bus.A[c_sh-1:0];
    assign w_sum   = bus.A + bus.B;
    assign w_diff  = bus.A - bus.B;

    always_comb begin
        w_alu = '0;
        case (bus.ALUOp)
            4'd0:    w_alu = w_sum;
            4'd1:    w_alu = w_diff;
            4'd2:    w_alu = bus.A | bus.B;
            4'd3:    w_alu = bus.A & bus.B;
            4'd4:    w_alu = bus.A ^ bus.B;
            4'd5:    w_alu = ~(bus.A | bus.B);
            4'd6:    w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            4'd7:    w_alu = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            4'd8:    w_alu = bus.B << w_shamt;
            4'd9:    w_alu = bus.B >> w_shamt;
            4'd10:   w_alu = $signed(bus.B) >>> w_shamt;
            4'd11:   w_alu = bus.B << (WIDTH / 2);
            default: w_alu = '0;
        endcase
    end

    assign bus.C = w_alu;

`ifdef ALU_OVF_EN
    // Overflow when operands (B inverted for SUB) share a sign that the
    // wrapped result does not.
    assign bus.ovf = ((bus.ALUOp == 4'd0) &&
                      (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != bus.A[WIDTH-1])) ||
                     ((bus.ALUOp == 4'd1) &&
                      (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                      (w_diff[WIDTH-1] != bus.A[WIDTH-1]));
`endif

    // ------------------------------------------------------------------------
    // MDU arithmetic, evaluated on the live operands; the result is captured
    // into the pending registers at the issue edge, which is what makes later
    // operand changes irrelevant.
    // ------------------------------------------------------------------------
    logic signed [2*WIDTH-1:0] w_a_sx;
    logic signed [2*WIDTH-1:0] w_b_sx;
    logic signed [2*WIDTH-1:0] w_prod_s;
    logic        [2*WIDTH-1:0] w_prod_u;
    logic signed [WIDTH-1:0]   w_quo_s;
    logic signed [WIDTH-1:0]   w_rem_s;
    logic        [WIDTH-1:0]   w_quo_u;
    logic        [WIDTH-1:0]   w_rem_u;
    logic                      w_b_zero;
    logic                      w_min_neg1;
    logic        [WIDTH-1:0]   w_res_hi;
    logic        [WIDTH-1:0]   w_res_lo;

    assign w_a_sx   = {{WIDTH{bus.A[WIDTH-1]}}, bus.A};
    assign w_b_sx   = {{WIDTH{bus.B[WIDTH-1]}}, bus.B};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};

    assign w_quo_s  = $signed(bus.A) / $signed(bus.B);
    assign w_rem_s  = $signed(bus.A) % $signed(bus.B);
    assign w_quo_u  = bus.A / bus.B;
    assign w_rem_u  = bus.A % bus.B;

    assign w_b_zero   = (bus.B == '0);
    assign w_min_neg1 = (bus.A == c_min) && (bus.B == '1);

    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        case (bus.MDOp)
            c_md_mult:  {w_res_hi, w_res_lo} = w_prod_s;
            c_md_multu: {w_res_hi, w_res_lo} = w_prod_u;
            c_md_div: begin
                if (w_b_zero) begin
                    w_res_lo = '1;
                    w_res_hi = bus.A;
                end else if (w_min_neg1) begin
                    // quotient does not fit; defined as MIN with no remainder
                    w_res_lo = c_min;
                    w_res_hi = '0;
                end else begin
                    w_res_lo = w_quo_s;
                    w_res_hi = w_rem_s;
                end
            end
            c_md_divu: begin
                if (w_b_zero) begin
                    w_res_lo = '1;
                    w_res_hi = bus.A;
                end else begin
                    w_res_lo = w_quo_u;
                    w_res_hi = w_rem_u;
                end
            end
            default: begin
                w_res_hi = '0;
                w_res_lo = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // MDU control FSM
    // ------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_md_issue;
    logic               w_mthi;
    logic               w_mtlo;
    logic               w_done;
    logic [c_cnt_w-1:0] w_cnt_load;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_pend_hi;
    logic [WIDTH-1:0]   r_pend_lo;

    assign w_cnt_load = ((bus.MDOp == c_md_mult) || (bus.MDOp == c_md_multu)) ?
                        c_mult_load : c_div_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_md_issue  = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.MDOp)
                        c_md_mult, c_md_multu, c_md_div, c_md_divu: begin
                            w_md_issue  = 1'b1;
                            w_state_nxt = S_RUN;
                        end
                        c_md_mthi: w_mthi = 1'b1;
                        c_md_mtlo: w_mtlo = 1'b1;
                        default:   ;
                    endcase
                end
            end
            S_RUN: begin
                // start is deliberately not examined here
                if (r_cnt == '0) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
        end else begin
            if (w_md_issue) begin
                r_cnt     <= w_cnt_load;
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
            end else if ((r_state == S_RUN) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end

            if (w_done) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end else begin
                if (w_mthi) begin
                    r_hi <= bus.A;
                end
                if (w_mtlo) begin
                    r_lo <= bus.A;
                end
            end
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;

endmodule
`default_nettype wire
